// File: rtl/alu_operand_stage_if.sv
// Bus bundle for the ID/EX operand stage: decode slot, forwarding sources,
// downstream stall/flush, and the ALU-facing outputs.
interface alu_operand_stage_if #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 6
);
  logic           id_valid;
  logic [DW-1:0]  id_rs_data;
  logic [DW-1:0]  id_rt_data;
  logic [DW-1:0]  id_imm;
  logic [RW-1:0]  id_rs;
  logic [RW-1:0]  id_rt;
  logic [RW-1:0]  id_rd;
  logic [OPW-1:0] id_op;
  logic           id_use_imm;
  logic           id_uses_rt;
  logic           id_reg_write;
  logic           id_mem_read;
  logic           id_mem_write;
  logic           stall_in;
  logic           flush;
  logic           exmem_reg_write;
  logic [RW-1:0]  exmem_rd;
  logic [DW-1:0]  exmem_result;
  logic           memwb_reg_write;
  logic [RW-1:0]  memwb_rd;
  logic [DW-1:0]  memwb_result;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_operation;
  logic [DW-1:0]  ex_store_data;
  logic           ex_valid;
  logic [RW-1:0]  ex_rd;
  logic           ex_reg_write;
  logic           ex_mem_read;
  logic           ex_mem_write;
  logic           hazard_stall;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_op,
           id_use_imm, id_uses_rt, id_reg_write, id_mem_read, id_mem_write,
           stall_in, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_operation, ex_store_data, ex_valid, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_op,
           id_use_imm, id_uses_rt, id_reg_write, id_mem_read, id_mem_write,
           stall_in, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_operation, ex_store_data, ex_valid, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use hazard detection and bubble insertion.
module alu_operand_stage #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 6
) (
  input logic               clk,
  input logic               reset,
  alu_operand_stage_if.slave bus
);

  localparam logic [OPW-1:0] OpPassB = '1;

  typedef struct packed {
    logic           valid;
    logic [RW-1:0]  rs;
    logic [RW-1:0]  rt;
    logic [RW-1:0]  rd;
    logic [DW-1:0]  rsData;
    logic [DW-1:0]  rtData;
    logic [DW-1:0]  imm;
    logic [OPW-1:0] op;
    logic           useImm;
    logic           regWrite;
    logic           memRead;
    logic           memWrite;
  } stage_t;

  stage_t         stage;
  stage_t         stageNext;
  logic           loadUse;
  logic [DW-1:0]  fwdRs;
  logic [DW-1:0]  fwdRt;

  // Newest producer wins; $0 is hardwired so it is never a forwarding target.
  function automatic logic [DW-1:0] forwardSel(
    input logic [RW-1:0] src,     input logic [DW-1:0] regVal,
    input logic          exWr,    input logic [RW-1:0] exRd, input logic [DW-1:0] exVal,
    input logic          wbWr,    input logic [RW-1:0] wbRd, input logic [DW-1:0] wbVal
  );
    if (exWr && exRd != '0 && exRd == src)      return exVal;
    else if (wbWr && wbRd != '0 && wbRd == src) return wbVal;
    else                                        return regVal;
  endfunction

  always_comb begin
    loadUse = !bus.stall_in && stage.valid && stage.memRead && stage.rd != '0 &&
              bus.id_valid &&
              (stage.rd == bus.id_rs || (bus.id_uses_rt && stage.rd == bus.id_rt));
  end

  // NOTE: start from a full default so every path assigns stageNext and no latch is inferred.
  always_comb begin
    stageNext = stage;
    if (bus.stall_in) begin
      stageNext = stage;
    end else if (bus.flush || loadUse) begin
      stageNext = '0;
    end else begin
      stageNext.valid    = bus.id_valid;
      stageNext.rs       = bus.id_rs;
      stageNext.rt       = bus.id_rt;
      stageNext.rd       = bus.id_rd;
      stageNext.rsData   = bus.id_rs_data;
      stageNext.rtData   = bus.id_rt_data;
      stageNext.imm      = bus.id_imm;
      stageNext.op       = bus.id_op;
      stageNext.useImm   = bus.id_use_imm;
      stageNext.regWrite = bus.id_valid & bus.id_reg_write;
      stageNext.memRead  = bus.id_valid & bus.id_mem_read;
      stageNext.memWrite = bus.id_valid & bus.id_mem_write;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) stage <= '0;
    else       stage <= stageNext;
  end

  always_comb begin
    fwdRs = forwardSel(stage.rs, stage.rsData,
                       bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                       bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
    fwdRt = forwardSel(stage.rt, stage.rtData,
                       bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                       bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
  end

  // A bubble presents constant operands and pass-b so the ALU cannot move flags.
  assign bus.alu_a         = stage.valid ? fwdRs : '0;
  assign bus.alu_b         = !stage.valid ? '0 : (stage.useImm ? stage.imm : fwdRt);
  assign bus.alu_operation = stage.valid ? stage.op : OpPassB;
  assign bus.ex_store_data = fwdRt;
  assign bus.ex_valid      = stage.valid;
  assign bus.ex_rd         = stage.rd;
  assign bus.ex_reg_write  = stage.regWrite;
  assign bus.ex_mem_read   = stage.memRead;
  assign bus.ex_mem_write  = stage.memWrite;
  assign bus.hazard_stall  = loadUse;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the in-flight EX instruction.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic reset;
  int   nTests = 0;
  int   nFail  = 0;

  alu_operand_stage_if #(.DW(32), .RW(5), .OPW(6)) bus ();

  alu_operand_stage #(.DW(32), .RW(5), .OPW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsData, rtData, imm;
    logic [5:0]  op;
    logic        useImm, regWrite, memRead, memWrite;
  } model_t;

  task automatic set_idle();
    bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_op = 0;
    bus.id_use_imm = 0; bus.id_uses_rt = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.stall_in = 0; bus.flush = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    nTests++; if (bus.ex_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", bus.ex_valid); end
    nTests++; if (bus.alu_operation !== 6'h3F) begin nFail++; $display("FAIL reset_op: got %h want 3f", bus.alu_operation); end
    nTests++; if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin nFail++; $display("FAIL reset_ab: got a=%h b=%h want 0/0", bus.alu_a, bus.alu_b); end
    nTests++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.hazard_stall} !== 4'b0) begin
      nFail++; $display("FAIL reset_ctrl: got %b want 0000", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.hazard_stall});
    end
  endtask

  task automatic test_basic();
    set_idle();
    bus.id_valid = 1; bus.id_op = 6'h20; bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 3;
    bus.id_rs_data = 5; bus.id_rt_data = 7; bus.id_uses_rt = 1; bus.id_reg_write = 1;
    step();
    set_idle();
    @(negedge clk);
    nTests++; if (bus.alu_a !== 32'd5) begin nFail++; $display("FAIL basic_a: got %h want 5", bus.alu_a); end
    nTests++; if (bus.alu_b !== 32'd7) begin nFail++; $display("FAIL basic_b: got %h want 7", bus.alu_b); end
    nTests++; if (bus.ex_valid !== 1'b1 || bus.alu_operation !== 6'h20) begin
      nFail++; $display("FAIL basic_ctrl: got valid=%b op=%h want 1/20", bus.ex_valid, bus.alu_operation);
    end
    nTests++; if (bus.ex_rd !== 5'd3 || bus.ex_reg_write !== 1'b1) begin
      nFail++; $display("FAIL basic_rd: got rd=%0d rw=%b want 3/1", bus.ex_rd, bus.ex_reg_write);
    end
  endtask

  task automatic test_forward_priority();
    set_idle();
    bus.id_valid = 1; bus.id_op = 6'h20; bus.id_rs = 3; bus.id_rs_data = 32'h99;
    step();
    set_idle();
    bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_result = 32'h11;
    bus.memwb_reg_write = 1; bus.memwb_rd = 3; bus.memwb_result = 32'h22;
    @(negedge clk);
    nTests++; if (bus.alu_a !== 32'h11) begin nFail++; $display("FAIL fwd_exmem_first: got %h want 11", bus.alu_a); end
    bus.exmem_reg_write = 0;
    #1;
    nTests++; if (bus.alu_a !== 32'h22) begin nFail++; $display("FAIL fwd_memwb: got %h want 22", bus.alu_a); end
    bus.memwb_rd = 4;
    #1;
    nTests++; if (bus.alu_a !== 32'h99) begin nFail++; $display("FAIL fwd_none: got %h want 99", bus.alu_a); end
  endtask

  task automatic test_zero_reg();
    set_idle();
    bus.id_valid = 1; bus.id_op = 6'h20; bus.id_rs = 0; bus.id_rs_data = 0;
    step();
    set_idle();
    bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 32'hFF;
    bus.memwb_reg_write = 1; bus.memwb_rd = 0; bus.memwb_result = 32'hEE;
    @(negedge clk);
    nTests++; if (bus.alu_a !== 32'h0) begin nFail++; $display("FAIL zero_reg: got %h want 0", bus.alu_a); end
  endtask

  task automatic test_load_use();
    set_idle();
    bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rd = 4; bus.id_op = 6'h20;
    step();
    set_idle();
    bus.id_valid = 1; bus.id_op = 6'h22; bus.id_rs = 1; bus.id_rt = 4; bus.id_uses_rt = 1;
    bus.id_rs_data = 32'h1; bus.id_rt_data = 32'h9; bus.id_rd = 7; bus.id_reg_write = 1;
    @(negedge clk);
    nTests++; if (bus.hazard_stall !== 1'b1) begin nFail++; $display("FAIL lu_hazard: got %b want 1", bus.hazard_stall); end
    step();
    @(negedge clk);
    nTests++; if (bus.hazard_stall !== 1'b0) begin nFail++; $display("FAIL lu_one_cycle: got %b want 0", bus.hazard_stall); end
    nTests++; if (bus.ex_valid !== 1'b0 || bus.alu_operation !== 6'h3F || bus.ex_reg_write !== 1'b0) begin
      nFail++; $display("FAIL lu_bubble: got valid=%b op=%h rw=%b want 0/3f/0", bus.ex_valid, bus.alu_operation, bus.ex_reg_write);
    end
    nTests++; if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin
      nFail++; $display("FAIL lu_bubble_ab: got a=%h b=%h want 0/0", bus.alu_a, bus.alu_b);
    end
    step();
    set_idle();
    bus.memwb_reg_write = 1; bus.memwb_rd = 4; bus.memwb_result = 32'h55;
    @(negedge clk);
    nTests++; if (bus.ex_valid !== 1'b1 || bus.alu_operation !== 6'h22) begin
      nFail++; $display("FAIL lu_retry: got valid=%b op=%h want 1/22", bus.ex_valid, bus.alu_operation);
    end
    nTests++; if (bus.alu_b !== 32'h55) begin nFail++; $display("FAIL lu_retry_fwd: got %h want 55", bus.alu_b); end
  endtask

  task automatic test_stall_flush();
    set_idle();
    bus.id_valid = 1; bus.id_op = 6'h21; bus.id_rs_data = 32'h100; bus.id_rd = 6;
    bus.id_reg_write = 1; bus.id_mem_read = 1;
    step();
    set_idle();
    bus.stall_in = 1; bus.flush = 1;
    bus.id_valid = 1; bus.id_rs = 6; bus.id_op = 6'h2A; bus.id_rd = 9;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      nTests++; if (bus.hazard_stall !== 1'b0) begin nFail++; $display("FAIL stall_hz_c%0d: got %b want 0", c, bus.hazard_stall); end
      nTests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || bus.alu_operation !== 6'h21 || bus.alu_a !== 32'h100) begin
        nFail++; $display("FAIL stall_hold_c%0d: got valid=%b rd=%0d op=%h a=%h want 1/6/21/100",
                          c, bus.ex_valid, bus.ex_rd, bus.alu_operation, bus.alu_a);
      end
      step();
    end
    bus.stall_in = 0;
    @(negedge clk);
    nTests++; if (bus.hazard_stall !== 1'b1) begin nFail++; $display("FAIL release_hz: got %b want 1", bus.hazard_stall); end
    step();
    bus.flush = 0; bus.id_rs = 2;
    @(negedge clk);
    nTests++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
      nFail++; $display("FAIL release_flush: got valid=%b mr=%b want 0/0", bus.ex_valid, bus.ex_mem_read);
    end
    step();
    set_idle();
    @(negedge clk);
    nTests++; if (bus.ex_valid !== 1'b1 || bus.alu_operation !== 6'h2A || bus.ex_rd !== 5'd9) begin
      nFail++; $display("FAIL after_flush: got valid=%b op=%h rd=%0d want 1/2a/9", bus.ex_valid, bus.alu_operation, bus.ex_rd);
    end
  endtask

  task automatic test_store_imm();
    set_idle();
    bus.id_valid = 1; bus.id_op = 6'h20; bus.id_use_imm = 1; bus.id_imm = 8; bus.id_uses_rt = 1;
    bus.id_rt = 5; bus.id_rt_data = 32'h1; bus.id_mem_write = 1;
    step();
    set_idle();
    bus.memwb_reg_write = 1; bus.memwb_rd = 5; bus.memwb_result = 32'hAB;
    @(negedge clk);
    nTests++; if (bus.alu_b !== 32'd8) begin nFail++; $display("FAIL store_b: got %h want 8", bus.alu_b); end
    nTests++; if (bus.ex_store_data !== 32'hAB) begin nFail++; $display("FAIL store_data: got %h want ab", bus.ex_store_data); end
    nTests++; if (bus.ex_mem_write !== 1'b1 || bus.ex_reg_write !== 1'b0) begin
      nFail++; $display("FAIL store_ctrl: got mw=%b rw=%b want 1/0", bus.ex_mem_write, bus.ex_reg_write);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] regVal);
    if (bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == src) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == src) return bus.memwb_result;
    return regVal;
  endfunction

  task automatic test_random();
    model_t      m;
    logic        expHz;
    logic [31:0] expA, expB, expSt;
    logic [5:0]  expOp;
    do_reset();
    m = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.id_valid        = ($urandom_range(0, 3) != 0);
      bus.id_rs           = 5'($urandom_range(0, 3));
      bus.id_rt           = 5'($urandom_range(0, 3));
      bus.id_rd           = 5'($urandom_range(0, 3));
      bus.id_rs_data      = $urandom;
      bus.id_rt_data      = $urandom;
      bus.id_imm          = $urandom;
      bus.id_op           = 6'($urandom_range(0, 62));
      bus.id_use_imm      = 1'($urandom);
      bus.id_uses_rt      = 1'($urandom);
      bus.id_reg_write    = 1'($urandom);
      bus.id_mem_read     = ($urandom_range(0, 2) == 0);
      bus.id_mem_write    = ($urandom_range(0, 3) == 0);
      bus.stall_in        = ($urandom_range(0, 4) == 0);
      bus.flush           = ($urandom_range(0, 5) == 0);
      bus.exmem_reg_write = 1'($urandom);
      bus.exmem_rd        = 5'($urandom_range(0, 3));
      bus.exmem_result    = $urandom;
      bus.memwb_reg_write = 1'($urandom);
      bus.memwb_rd        = 5'($urandom_range(0, 3));
      bus.memwb_result    = $urandom;
      @(negedge clk);

      expHz = !bus.stall_in && m.valid && m.memRead && m.rd != 0 && bus.id_valid &&
              (m.rd == bus.id_rs || (bus.id_uses_rt && m.rd == bus.id_rt));
      expSt = ref_fwd(m.rt, m.rtData);
      expA  = m.valid ? ref_fwd(m.rs, m.rsData) : 32'h0;
      expB  = m.valid ? (m.useImm ? m.imm : expSt) : 32'h0;
      expOp = m.valid ? m.op : 6'h3F;

      nTests++; if (bus.hazard_stall !== expHz) begin nFail++; $display("FAIL rnd_hz cyc%0d: got %b want %b", cyc, bus.hazard_stall, expHz); end
      nTests++; if (bus.alu_a !== expA) begin nFail++; $display("FAIL rnd_a cyc%0d: got %h want %h", cyc, bus.alu_a, expA); end
      nTests++; if (bus.alu_b !== expB) begin nFail++; $display("FAIL rnd_b cyc%0d: got %h want %h", cyc, bus.alu_b, expB); end
      nTests++; if (bus.alu_operation !== expOp) begin nFail++; $display("FAIL rnd_op cyc%0d: got %h want %h", cyc, bus.alu_operation, expOp); end
      nTests++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== {m.valid, m.regWrite, m.memRead, m.memWrite}) begin
        nFail++; $display("FAIL rnd_ctrl cyc%0d: got %b want %b", cyc,
                          {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
                          {m.valid, m.regWrite, m.memRead, m.memWrite});
      end
      if (m.valid) begin
        nTests++; if (bus.ex_store_data !== expSt || bus.ex_rd !== m.rd) begin
          nFail++; $display("FAIL rnd_store cyc%0d: got sd=%h rd=%0d want %h/%0d", cyc, bus.ex_store_data, bus.ex_rd, expSt, m.rd);
        end
      end

      if (bus.stall_in) begin
        m = m;
      end else if (bus.flush || expHz) begin
        m = '0;
      end else begin
        m.valid    = bus.id_valid;
        m.rs       = bus.id_rs;
        m.rt       = bus.id_rt;
        m.rd       = bus.id_rd;
        m.rsData   = bus.id_rs_data;
        m.rtData   = bus.id_rt_data;
        m.imm      = bus.id_imm;
        m.op       = bus.id_op;
        m.useImm   = bus.id_use_imm;
        m.regWrite = bus.id_valid && bus.id_reg_write;
        m.memRead  = bus.id_valid && bus.id_mem_read;
        m.memWrite = bus.id_valid && bus.id_mem_write;
      end
      step();
    end
  endtask

  initial begin
    reset = 1;
    set_idle();
    test_reset();
    test_basic();
    test_forward_priority();
    test_zero_reg();
    test_load_use();
    test_stall_flush();
    test_store_imm();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
